// File: rtl/queue_ptr_manager.sv
// Multi-queue ring pointer manager: 1-cycle registered responses, in-order op retire; requests stall on full op table or held response.
// Optional doorbell event stream when QUEUE_PTR_MANAGER_EVENT_EN is defined.
module queue_ptr_manager #(
    parameter int QUEUE_INDEX_WIDTH = 3,
    parameter int PTR_WIDTH         = 16,
    parameter int OP_TABLE_SIZE     = 8,
    parameter int REQ_TAG_WIDTH     = 8,
    parameter int AXIL_ADDR_WIDTH   = 16,
    parameter int AXIL_DATA_WIDTH   = 32,
    localparam int OPW = $clog2(OP_TABLE_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [QUEUE_INDEX_WIDTH-1:0] s_axis_dequeue_req_queue,
    input  logic [REQ_TAG_WIDTH-1:0]     s_axis_dequeue_req_tag,
    input  logic                         s_axis_dequeue_req_valid,
    output logic                         s_axis_dequeue_req_ready,
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_dequeue_resp_queue,
    output logic [PTR_WIDTH-1:0]         m_axis_dequeue_resp_ptr,
    output logic [REQ_TAG_WIDTH-1:0]     m_axis_dequeue_resp_tag,
    output logic [OPW-1:0]               m_axis_dequeue_resp_op_tag,
    output logic                         m_axis_dequeue_resp_empty,
    output logic                         m_axis_dequeue_resp_error,
    output logic                         m_axis_dequeue_resp_valid,
    input  logic                         m_axis_dequeue_resp_ready,
    input  logic [OPW-1:0]               s_axis_dequeue_commit_op_tag,
    input  logic                         s_axis_dequeue_commit_valid,
    output logic                         s_axis_dequeue_commit_ready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic [2:0]                   s_axil_awprot,
    input  logic                         s_axil_awvalid,
    output logic                         s_axil_awready,
    input  logic [AXIL_DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                         s_axil_wvalid,
    output logic                         s_axil_wready,
    output logic [1:0]                   s_axil_bresp,
    output logic                         s_axil_bvalid,
    input  logic                         s_axil_bready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic [2:0]                   s_axil_arprot,
    input  logic                         s_axil_arvalid,
    output logic                         s_axil_arready,
    output logic [AXIL_DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]                   s_axil_rresp,
    output logic                         s_axil_rvalid,
`ifdef QUEUE_PTR_MANAGER_EVENT_EN
    output logic [QUEUE_INDEX_WIDTH-1:0] m_axis_event_queue,
    output logic                         m_axis_event_valid,
`endif
    input  logic                         s_axil_rready,
    input  logic                         enable
);
    localparam int QN = 2 ** QUEUE_INDEX_WIDTH;

    logic                 q_active    [QN];
    logic [3:0]           q_log_size  [QN];
    logic [PTR_WIDTH-1:0] q_tail      [QN];
    logic [PTR_WIDTH-1:0] q_spec_head [QN];
    logic [PTR_WIDTH-1:0] q_head      [QN];
    logic                 q_overflow  [QN];

    logic [QUEUE_INDEX_WIDTH-1:0] op_queue [OP_TABLE_SIZE];
    logic [PTR_WIDTH-1:0]         op_ptr   [OP_TABLE_SIZE];
    logic [OP_TABLE_SIZE-1:0]     op_valid, op_committed;
    logic [OPW:0]                 op_wr, op_rd;
    logic [OPW-1:0]               wr_idx, rd_idx;
    logic                         op_full;

    logic [QUEUE_INDEX_WIDTH-1:0] rq, wq, ret_q;
    logic                         req_fire, rq_empty, alloc, retire;
    logic                         wr_fire, rd_fire, ctrl_wr, tail_wr, tail_ok;
    logic [PTR_WIDTH-1:0]         new_tail, tail_diff;
    logic [PTR_WIDTH:0]           tail_lim;
    logic [AXIL_DATA_WIDTH-1:0]   rd_word;
    logic                         unused_ok;

    assign wr_idx  = op_wr[OPW-1:0];
    assign rd_idx  = op_rd[OPW-1:0];
    assign op_full = (op_wr - op_rd) == (OPW+1)'(OP_TABLE_SIZE);

    assign s_axis_dequeue_req_ready   = !rst && enable && !op_full &&
                                        (!m_axis_dequeue_resp_valid || m_axis_dequeue_resp_ready);
    assign s_axis_dequeue_commit_ready = 1'b1;
    assign req_fire = s_axis_dequeue_req_valid && s_axis_dequeue_req_ready;
    assign rq       = s_axis_dequeue_req_queue;
    assign rq_empty = q_spec_head[rq] == q_tail[rq];
    assign alloc    = req_fire && q_active[rq] && !rq_empty;

    assign retire = op_valid[rd_idx] && op_committed[rd_idx];
    assign ret_q  = op_queue[rd_idx];

    assign s_axil_awready = !rst && s_axil_awvalid && s_axil_wvalid && !s_axil_bvalid;
    assign s_axil_wready  = s_axil_awready;
    assign s_axil_arready = !rst && !s_axil_rvalid;
    assign s_axil_bresp   = 2'b00;
    assign s_axil_rresp   = 2'b00;
    assign wr_fire = s_axil_awready;
    assign rd_fire = s_axil_arvalid && s_axil_arready;
    assign wq      = s_axil_awaddr[QUEUE_INDEX_WIDTH+3:4];
    assign ctrl_wr = wr_fire && s_axil_awaddr[3:0] == 4'h0;
    assign tail_wr = wr_fire && s_axil_awaddr[3:0] == 4'h4;

    // Doorbell window measured against the committed head, not spec_head.
    assign new_tail  = s_axil_wdata[PTR_WIDTH-1:0];
    assign tail_diff = new_tail - q_head[wq];
    assign tail_lim  = (PTR_WIDTH+1)'(1) << q_log_size[wq];
    assign tail_ok   = {1'b0, tail_diff} <= tail_lim;

    assign unused_ok = ^{s_axil_awprot, s_axil_arprot, s_axil_wstrb, s_axil_wdata,
                         s_axil_awaddr, s_axil_araddr};

    always_comb begin
        rd_word = '0;
        case (s_axil_araddr[3:0])
            4'h0: rd_word = AXIL_DATA_WIDTH'({q_overflow[s_axil_araddr[QUEUE_INDEX_WIDTH+3:4]], 19'b0,
                                              q_log_size[s_axil_araddr[QUEUE_INDEX_WIDTH+3:4]], 7'b0,
                                              q_active[s_axil_araddr[QUEUE_INDEX_WIDTH+3:4]]});
            4'h4: rd_word = AXIL_DATA_WIDTH'(q_tail[s_axil_araddr[QUEUE_INDEX_WIDTH+3:4]]);
            4'h8: rd_word = AXIL_DATA_WIDTH'(q_head[s_axil_araddr[QUEUE_INDEX_WIDTH+3:4]]);
            default: rd_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < QN; i++) begin
                q_active[i]    <= 1'b0;
                q_log_size[i]  <= '0;
                q_tail[i]      <= '0;
                q_spec_head[i] <= '0;
                q_head[i]      <= '0;
                q_overflow[i]  <= 1'b0;
            end
        end else begin
            if (alloc)
                q_spec_head[rq] <= q_spec_head[rq] + PTR_WIDTH'(1);
            if (ctrl_wr) begin
                q_active[wq]   <= s_axil_wdata[0];
                q_log_size[wq] <= s_axil_wdata[11:8];
                if (s_axil_wdata[31])
                    q_overflow[wq] <= 1'b0;
                if (s_axil_wdata[0])
                    q_spec_head[wq] <= q_head[wq];
            end
            if (tail_wr) begin
                if (tail_ok)
                    q_tail[wq] <= new_tail;
                else
                    q_overflow[wq] <= 1'b1;
            end
            if (retire)
                q_head[ret_q] <= op_ptr[rd_idx] + PTR_WIDTH'(1);
        end
    end

    // Retire clears after commit so a commit racing the retire of the same entry is harmless.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_wr        <= '0;
            op_rd        <= '0;
            op_valid     <= '0;
            op_committed <= '0;
            for (int i = 0; i < OP_TABLE_SIZE; i++) begin
                op_queue[i] <= '0;
                op_ptr[i]   <= '0;
            end
        end else begin
            if (s_axis_dequeue_commit_valid && op_valid[s_axis_dequeue_commit_op_tag])
                op_committed[s_axis_dequeue_commit_op_tag] <= 1'b1;
            if (retire) begin
                op_valid[rd_idx]     <= 1'b0;
                op_committed[rd_idx] <= 1'b0;
                op_rd                <= op_rd + (OPW+1)'(1);
            end
            if (alloc) begin
                op_valid[wr_idx]     <= 1'b1;
                op_committed[wr_idx] <= 1'b0;
                op_queue[wr_idx]     <= rq;
                op_ptr[wr_idx]       <= q_spec_head[rq];
                op_wr                <= op_wr + (OPW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_dequeue_resp_valid  <= 1'b0;
            m_axis_dequeue_resp_queue  <= '0;
            m_axis_dequeue_resp_ptr    <= '0;
            m_axis_dequeue_resp_tag    <= '0;
            m_axis_dequeue_resp_op_tag <= '0;
            m_axis_dequeue_resp_empty  <= 1'b0;
            m_axis_dequeue_resp_error  <= 1'b0;
        end else if (req_fire) begin
            m_axis_dequeue_resp_valid  <= 1'b1;
            m_axis_dequeue_resp_queue  <= rq;
            m_axis_dequeue_resp_ptr    <= q_spec_head[rq];
            m_axis_dequeue_resp_tag    <= s_axis_dequeue_req_tag;
            m_axis_dequeue_resp_op_tag <= alloc ? wr_idx : '0;
            m_axis_dequeue_resp_empty  <= !q_active[rq] || rq_empty;
            m_axis_dequeue_resp_error  <= !q_active[rq];
        end else if (m_axis_dequeue_resp_ready) begin
            m_axis_dequeue_resp_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_axil_bvalid <= 1'b0;
            s_axil_rvalid <= 1'b0;
            s_axil_rdata  <= '0;
        end else begin
            if (wr_fire)
                s_axil_bvalid <= 1'b1;
            else if (s_axil_bready)
                s_axil_bvalid <= 1'b0;
            if (rd_fire) begin
                s_axil_rvalid <= 1'b1;
                s_axil_rdata  <= rd_word;
            end else if (s_axil_rready) begin
                s_axil_rvalid <= 1'b0;
            end
        end
    end

`ifdef QUEUE_PTR_MANAGER_EVENT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_event_valid <= 1'b0;
            m_axis_event_queue <= '0;
        end else begin
            m_axis_event_valid <= 1'b0;
            if (tail_wr && tail_ok && q_active[wq] &&
                q_tail[wq] == q_spec_head[wq] && new_tail != q_spec_head[wq]) begin
                m_axis_event_valid <= 1'b1;
                m_axis_event_queue <= wq;
            end
        end
    end
`endif
endmodule

// File: tb/tb_queue_ptr_manager.sv
// Directed bench for queue_ptr_manager: programming, dequeue, in-order retire, overflow, table-full, reset.
module tb_queue_ptr_manager;
    logic        clk = 0;
    logic        rst;
    logic [2:0]  req_queue;
    logic [7:0]  req_tag;
    logic        req_valid, req_ready;
    logic [2:0]  resp_queue;
    logic [15:0] resp_ptr;
    logic [7:0]  resp_tag;
    logic [2:0]  resp_op_tag;
    logic        resp_empty, resp_error, resp_valid, resp_ready;
    logic [2:0]  commit_op_tag;
    logic        commit_valid, commit_ready;
    logic [15:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        enable;
`ifdef QUEUE_PTR_MANAGER_EVENT_EN
    logic [2:0]  event_queue;
    logic        event_valid;
`endif
    int errors = 0;
    int checks = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    queue_ptr_manager dut (
        .clk(clk), .rst(rst),
        .s_axis_dequeue_req_queue(req_queue), .s_axis_dequeue_req_tag(req_tag),
        .s_axis_dequeue_req_valid(req_valid), .s_axis_dequeue_req_ready(req_ready),
        .m_axis_dequeue_resp_queue(resp_queue), .m_axis_dequeue_resp_ptr(resp_ptr),
        .m_axis_dequeue_resp_tag(resp_tag), .m_axis_dequeue_resp_op_tag(resp_op_tag),
        .m_axis_dequeue_resp_empty(resp_empty), .m_axis_dequeue_resp_error(resp_error),
        .m_axis_dequeue_resp_valid(resp_valid), .m_axis_dequeue_resp_ready(resp_ready),
        .s_axis_dequeue_commit_op_tag(commit_op_tag), .s_axis_dequeue_commit_valid(commit_valid),
        .s_axis_dequeue_commit_ready(commit_ready),
        .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid),
`ifdef QUEUE_PTR_MANAGER_EVENT_EN
        .m_axis_event_queue(event_queue), .m_axis_event_valid(event_valid),
`endif
        .s_axil_rready(rready), .enable(enable)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_wr(input logic [15:0] a, input logic [31:0] d);
        int n = 0;
        awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
        while (!awready && n < 20) begin tick(); n++; end
        chk("aw_handshake", {31'b0, awready}, 1);
        tick();
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_rd(input logic [15:0] a, output logic [31:0] d);
        int n = 0;
        araddr = a; arvalid = 1;
        while (!arready && n < 20) begin tick(); n++; end
        chk("ar_handshake", {31'b0, arready}, 1);
        tick();
        chk("r_valid", {31'b0, rvalid}, 1);
        d = rdata;
        arvalid = 0;
    endtask

    task automatic req(input logic [2:0] q, input logic [7:0] t);
        int n = 0;
        req_queue = q; req_tag = t; req_valid = 1;
        while (!req_ready && n < 20) begin tick(); n++; end
        chk("req_handshake", {31'b0, req_ready}, 1);
        tick();
        req_valid = 0;
    endtask

    task automatic chk_resp(input string tag, input logic [2:0] q, input logic [15:0] p,
                            input logic [7:0] t, input logic [2:0] op, input logic e, input logic er);
        chk({tag, "_vld"}, {31'b0, resp_valid}, 1);
        chk({tag, "_q"}, {29'b0, resp_queue}, {29'b0, q});
        chk({tag, "_tag"}, {24'b0, resp_tag}, {24'b0, t});
        chk({tag, "_optag"}, {29'b0, resp_op_tag}, {29'b0, op});
        chk({tag, "_empty"}, {31'b0, resp_empty}, {31'b0, e});
        chk({tag, "_error"}, {31'b0, resp_error}, {31'b0, er});
        if (!e) chk({tag, "_ptr"}, {16'b0, resp_ptr}, {16'b0, p});
    endtask

    task automatic commit(input logic [2:0] t);
        commit_op_tag = t; commit_valid = 1;
        tick();
        commit_valid = 0;
    endtask

    initial begin
        rst = 1; enable = 0;
        req_queue = 0; req_tag = 0; req_valid = 0; resp_ready = 1;
        commit_op_tag = 0; commit_valid = 0;
        awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 4'hf; wvalid = 0; bready = 1;
        araddr = 0; arprot = 0; arvalid = 0; rready = 1;
        repeat (2) tick();
        chk("rst_req_ready", {31'b0, req_ready}, 0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 0);
        chk("rst_commit_ready", {31'b0, commit_ready}, 1);
        chk("rst_arready", {31'b0, arready}, 0);
        chk("rst_bvalid", {31'b0, bvalid}, 0);
        chk("rst_rvalid", {31'b0, rvalid}, 0);
        chk("rst_resp_ptr", {16'b0, resp_ptr}, 0);
        rst = 0; enable = 1;
        tick();

        // queue 2: active, log_size 4, tail 3
        axi_wr(16'h0020, 32'h0000_0401);
        axi_wr(16'h0024, 32'd3);
        axi_rd(16'h0020, rd); chk("q2_ctrl", rd, 32'h401);
        axi_rd(16'h0024, rd); chk("q2_tail", rd, 3);
        axi_rd(16'h0028, rd); chk("q2_head0", rd, 0);

        req(2, 8'h11); chk_resp("r0", 2, 0, 8'h11, 0, 0, 0);
        req(2, 8'h12); chk_resp("r1", 2, 1, 8'h12, 1, 0, 0);
        req(2, 8'h13); chk_resp("r2", 2, 2, 8'h13, 2, 0, 0);
        req(2, 8'h14); chk_resp("r3_empty", 2, 0, 8'h14, 0, 1, 0);
        req(5, 8'h55); chk_resp("q5_inactive", 5, 0, 8'h55, 0, 1, 1);

        // out-of-order commits retire strictly in order
        commit(2); repeat (3) tick();
        axi_rd(16'h0028, rd); chk("head_after_c2", rd, 0);
        commit(0); repeat (3) tick();
        axi_rd(16'h0028, rd); chk("head_after_c0", rd, 1);
        commit(1); repeat (3) tick();
        axi_rd(16'h0028, rd); chk("head_after_c1", rd, 3);

        axi_wr(16'h0024, 32'd5);
        req(2, 8'h20); chk_resp("op_seq", 2, 3, 8'h20, 3, 0, 0);
        commit(3); repeat (3) tick();
        axi_rd(16'h0028, rd); chk("head_after_c3", rd, 4);

        // doorbell window: log_size 2, head 0
        axi_wr(16'h0030, 32'h0000_0201);
        axi_wr(16'h0034, 32'd5);
        axi_rd(16'h0034, rd); chk("ovf_tail_kept", rd, 0);
        axi_rd(16'h0030, rd); chk("ovf_set", rd, 32'h8000_0201);
        axi_wr(16'h0030, 32'h8000_0201);
        axi_rd(16'h0030, rd); chk("ovf_cleared", rd, 32'h201);
        axi_wr(16'h0034, 32'd4);
        axi_rd(16'h0034, rd); chk("tail_at_limit", rd, 4);
        axi_rd(16'h003C, rd); chk("unmapped_rd", rd, 0);

`ifdef QUEUE_PTR_MANAGER_EVENT_EN
        axi_wr(16'h0010, 32'h0000_0401);
        chk("ev_ctrl_none", {31'b0, event_valid}, 0);
        axi_wr(16'h0014, 32'd1);
        chk("ev_pulse", {31'b0, event_valid}, 1);
        chk("ev_queue", {29'b0, event_queue}, 1);
        tick();
        chk("ev_one_cycle", {31'b0, event_valid}, 0);
        axi_wr(16'h0014, 32'd2);
        chk("ev_nonempty_none", {31'b0, event_valid}, 0);
`endif

        // fill op table with 8 uncommitted ops
        axi_wr(16'h0024, 32'd20);
        for (int i = 0; i < 8; i++) begin
            req(2, 8'(8'h60 + i));
            chk_resp("fill", 2, 16'(4 + i), 8'(8'h60 + i), 3'((4 + i) % 8), 0, 0);
        end
        chk("full_ready", {31'b0, req_ready}, 0);
        commit(4);
        chk("full_commit_edge", {31'b0, req_ready}, 0);
        tick();
        chk("full_freed", {31'b0, req_ready}, 1);
        req(2, 8'h70); chk_resp("refill", 2, 12, 8'h70, 4, 0, 0);
        chk("refull_ready", {31'b0, req_ready}, 0);

        // mid-operation reset drops response and op table
        rst = 1; #1;
        chk("midrst_resp", {31'b0, resp_valid}, 0);
        chk("midrst_ready", {31'b0, req_ready}, 0);
        tick();
        rst = 0;
        tick();
        chk("postrst_ready", {31'b0, req_ready}, 1);
        axi_rd(16'h0020, rd); chk("postrst_ctrl", rd, 0);
        axi_rd(16'h0024, rd); chk("postrst_tail", rd, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
